// File: rtl/io_reg_arb_pkg.sv
// Shared types and constants for the IO register write arbiter.
package io_reg_arb_pkg;

    localparam int IO_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/io_reg_arb_rr_pick.sv
// Combinational round-robin picker: rotate requests so rr_ptr sits at bit 0,
// take the lowest set bit, then rotate the index back.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic               found,
    output logic [ID_W-1:0]    idx
);

    localparam logic [ID_W:0] NREQ_C = NUM_REQ[ID_W:0];

    logic [2*NUM_REQ-1:0] dbl_s;
    logic [NUM_REQ-1:0]   rot_s;
    logic [ID_W-1:0]      off_s;
    logic [ID_W:0]        sum_s;
    logic [ID_W:0]        wrap_s;

    // Rotate, fixed-priority encode (lowest index wins), un-rotate modulo NUM_REQ
    always_comb begin
        dbl_s = {req, req} >> rr_ptr;
        rot_s = dbl_s[NUM_REQ-1:0];
        off_s = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            off_s = rot_s[i] ? i[ID_W-1:0] : off_s;
        end
        sum_s  = {1'b0, off_s} + {1'b0, rr_ptr};
        wrap_s = sum_s - NREQ_C;
        idx    = (sum_s >= NREQ_C) ? wrap_s[ID_W-1:0] : sum_s[ID_W-1:0];
        found  = |req;
    end

endmodule

// File: rtl/io_reg_arb.sv
// Round-robin write arbiter in front of the IO register; each grant runs a
// fixed capture -> write -> acknowledge sequence.
module io_reg_arb
    import io_reg_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int DATA_W  = IO_DATA_W,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        ack,
    output logic [ID_W-1:0]           grant_id,
    output logic                      busy,
    output logic                      wr_en,
    output logic [DATA_W-1:0]         wr_data
);

    localparam logic [ID_W-1:0] LAST_C = ID_W'(NUM_REQ - 1);
    localparam logic [ID_W-1:0] ONE_C  = ID_W'(1);

    arb_state_t          state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]     grant_q, grant_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                found_s;
    logic [ID_W-1:0]     idx_s;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .found  (found_s),
        .idx    (idx_s)
    );

    // Next-state logic: grant and capture in IDLE, advance the pointer in DONE
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        data_d   = data_q;
        case (state_q)
            IDLE: begin
                if (found_s) begin
                    grant_d = idx_s;
                    data_d  = req_data[idx_s*DATA_W +: DATA_W];
                    state_d = WRITE;
                end else begin
                    state_d = IDLE;
                end
            end
            WRITE: state_d = DONE;
            DONE: begin
                rr_ptr_d = (grant_q == LAST_C) ? '0 : grant_q + ONE_C;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset abandons any in-flight transaction
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            data_q   <= data_d;
        end
    end

    // Outputs decoded purely from registered state
    always_comb begin
        ack      = '0;
        wr_en    = (state_q == WRITE);
        busy     = (state_q != IDLE);
        grant_id = grant_q;
        wr_data  = data_q;
        if (state_q == DONE) begin
            ack[grant_q] = 1'b1;
        end else begin
            ack = '0;
        end
    end

endmodule

// File: tb/tb_io_reg_arb.sv
// Scoreboard bench for io_reg_arb: stimulus pushes expected writes/acks with
// their cycle numbers, a negedge monitor pops and compares them.
module tb_io_reg_arb;

    localparam int N  = 4;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    ack;
    logic [1:0]      grant_id;
    logic            busy;
    logic            wr_en;
    logic [DW-1:0]   wr_data;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t;
    logic [7:0] io_model = 8'h00;

    typedef struct { logic [7:0] data; logic [1:0] gid; int cyc; } wr_exp_t;
    typedef struct { logic [3:0] ackv; int cyc; } ack_exp_t;

    wr_exp_t  wq[$];
    ack_exp_t aq[$];
    wr_exp_t  we;
    ack_exp_t ae;

    io_reg_arb #(.NUM_REQ(N), .DATA_W(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .ack      (ack),
        .grant_id (grant_id),
        .busy     (busy),
        .wr_en    (wr_en),
        .wr_data  (wr_data)
    );

    always #5 clk = ~clk;

    // Cycle counter and a model of the IO register fed by the write port
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (wr_en === 1'b1) io_model <= wr_data;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_txn(input logic [1:0] id, input logic [7:0] d, input int t0);
        logic [3:0] v;
        v = 4'b0001 << id;
        wq.push_back('{data: d, gid: id, cyc: t0 + 1});
        aq.push_back('{ackv: v, cyc: t0 + 2});
    endtask

    // Monitor: every write strobe and ack pulse must match the next expectation
    always @(negedge clk) begin
        if (cyc > 0 && wr_en === 1'b1) begin
            if (wq.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_wr: got data %0h at cycle %0d, required none", wr_data, cyc);
            end else begin
                we = wq.pop_front();
                check("wr_data", wr_data, we.data);
                check("wr_gid", grant_id, we.gid);
                check("wr_cycle", cyc, we.cyc);
                check("wr_busy", busy, 1);
            end
        end
        if (cyc > 0 && ack !== 4'b0000) begin
            if (aq.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_ack: got %b at cycle %0d, required none", ack, cyc);
            end else begin
                ae = aq.pop_front();
                check("ack_vec", ack, ae.ackv);
                check("ack_cycle", cyc, ae.cyc);
                check("ack_busy", busy, 1);
            end
        end
    end

    initial begin
        rst = 1'b1; req = '0; req_data = '0;
        step();
        // reset held with random requests
        for (int i = 0; i < 2; i++) begin
            req = 4'($urandom); req_data = $urandom;
            @(negedge clk);
            check("rst_wr_en", wr_en, 0);
            check("rst_ack", ack, 0);
            check("rst_busy", busy, 0);
            check("rst_gid", grant_id, 0);
            step();
        end
        rst = 1'b0; req = '0; req_data = '0;
        @(negedge clk);
        check("rel_wr_en", wr_en, 0);
        check("rel_busy", busy, 0);
        check("rel_gid", grant_id, 0);
        step();

        // single request from requester 2
        req_data[2*DW +: DW] = 8'hA5; req = 4'b0100; t = cyc;
        push_txn(2'd2, 8'hA5, t);
        step(); step(); step();
        req = '0;
        step();

        // all four at once right after reset: order 0,1,2,3
        rst = 1'b1; step();
        rst = 1'b0;
        req_data = {8'h43, 8'h32, 8'h21, 8'h10}; req = 4'b1111; t = cyc;
        push_txn(2'd0, 8'h10, t);
        push_txn(2'd1, 8'h21, t + 3);
        push_txn(2'd2, 8'h32, t + 6);
        push_txn(2'd3, 8'h43, t + 9);
        for (int k = 0; k < 4; k++) begin
            repeat (3) step();
            req[k] = 1'b0;
        end
        step();
        check("reg_after_all4", io_model, 8'h43);

        // grant 2 so the pointer sits at 3, then 1010 wraps: 3 then 1
        req_data[2*DW +: DW] = 8'h77; req = 4'b0100; t = cyc;
        push_txn(2'd2, 8'h77, t);
        repeat (3) step();
        req = '0;
        req_data[3*DW +: DW] = 8'hC3; req_data[1*DW +: DW] = 8'h1E; req = 4'b1010; t = cyc;
        push_txn(2'd3, 8'hC3, t);
        push_txn(2'd1, 8'h1E, t + 3);
        repeat (3) step();
        req[3] = 1'b0;
        repeat (3) step();
        req[1] = 1'b0;

        // grant 0 so the pointer sits at 1 before the mid-write reset
        req_data[0 +: DW] = 8'h3C; req = 4'b0001; t = cyc;
        push_txn(2'd0, 8'h3C, t);
        repeat (3) step();
        req = '0;

        // reset during WRITE: no ack, pointer back to 0 so 0011 grants 0 first
        req_data[2*DW +: DW] = 8'h99; req = 4'b0100; t = cyc;
        wq.push_back('{data: 8'h99, gid: 2'd2, cyc: t + 1});
        step();
        rst = 1'b1; req = '0;
        step();
        check("abort_wr_en", wr_en, 0);
        check("abort_ack", ack, 0);
        check("abort_busy", busy, 0);
        check("abort_gid", grant_id, 0);
        rst = 1'b0;
        req_data[0 +: DW] = 8'h11; req_data[1*DW +: DW] = 8'h22; req = 4'b0011; t = cyc;
        push_txn(2'd0, 8'h11, t);
        push_txn(2'd1, 8'h22, t + 3);
        repeat (3) step();
        req[0] = 1'b0;
        repeat (3) step();
        req[1] = 1'b0;

        // request dropped after one cycle still completes with captured data
        req_data[1*DW +: DW] = 8'h5C; req = 4'b0010; t = cyc;
        push_txn(2'd1, 8'h5C, t);
        step();
        req = '0; req_data[1*DW +: DW] = 8'h00;
        repeat (4) step();
        check("reg_after_drop", io_model, 8'h5C);
        check("idle_busy", busy, 0);
        check("wq_drained", wq.size(), 0);
        check("aq_drained", aq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
